// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter and its prescaler.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int N_DEFAULT        = 24;
  localparam int MODULUS_DEFAULT  = 1 << 24;
  localparam int PRESCALE_DEFAULT = 1;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_prescaler.sv
// Divides enabled clocks by PRESCALE and flags the step clock; collapses to a
// plain pass-through of En when PRESCALE is 1.
module mod_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic En,
  input  logic Clr,
  output logic Step
);

  generate
    if (PRESCALE == 1) begin : g_direct
      logic unused_ok;
      assign unused_ok = ^{Clock, Resetn, Clr};
      assign Step      = En;
    end else begin : g_div
      localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
      localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] p_q;
      logic [PW-1:0] p_d;

      always_comb begin
        p_d = p_q;
        if (Clr) begin
          p_d = '0;
        end else if (En) begin
          p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
        end
      end

      always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
          p_q <= '0;
        end else begin
          p_q <= p_d;
        end
      end

      assign Step = En && (p_q == P_LAST);
    end
  endgenerate

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo-MODULUS counter with prescaler, load clamp and Tick/Tc pulses.
// Define MOD_COUNTER_SATURATE_EN to hold at the terminal value instead of wrapping.
module mod_counter
  import counter_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int MODULUS  = MODULUS_DEFAULT,
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         En,
  input  logic         Dir,
  input  logic         Load,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         Tick,
  output logic         Tc
);

  generate
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << N) || PRESCALE < 1) begin : g_bad_cfg
      $error("mod_counter: illegal MODULUS/PRESCALE for width N");
    end
  endgenerate

`ifdef MOD_COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // One extra bit so MODULUS == 2**N is representable.
  localparam logic [N:0] MOD_LAST = (N+1)'(MODULUS - 1);

  logic [N-1:0] q_q, q_d;
  logic         tick_q, tick_d;
  logic         tc_q, tc_d;
  logic         step;
  logic [N:0]   q_ext;
  logic [N:0]   d_ext;

  mod_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .Clock  (Clock),
    .Resetn (Resetn),
    .En     (En),
    .Clr    (Load),
    .Step   (step)
  );

  assign q_ext = {1'b0, q_q};
  assign d_ext = {1'b0, D};

  always_comb begin
    q_d    = q_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (Load) begin
      q_d = (d_ext > MOD_LAST) ? N'(MOD_LAST) : D;
    end else if (step) begin
      tick_d = 1'b1;
      if (Dir == DIR_UP) begin
        if (q_ext == MOD_LAST) begin
          tc_d = 1'b1;
          q_d  = SATURATE ? q_q : '0;
        end else begin
          q_d = N'(q_ext + 1'b1);
        end
      end else begin
        if (q_ext == '0) begin
          tc_d = 1'b1;
          q_d  = SATURATE ? q_q : N'(MOD_LAST);
        end else begin
          q_d = N'(q_ext - 1'b1);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q_q    <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign Q    = q_q;
  assign Tick = tick_q;
  assign Tc   = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: PRESCALE=1 and PRESCALE=3 instances, N=4, MODULUS=10.
module tb_mod_counter;

`ifdef MOD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       Clock;
  logic       Resetn;
  logic       En;
  logic       Dir;
  logic       Load;
  logic [3:0] D;
  logic [3:0] Q1, Q3;
  logic       Tick1, Tick3, Tc1, Tc3;

  int n_cmp = 0;
  int n_err = 0;

  mod_counter #(.N(4), .MODULUS(10), .PRESCALE(1)) u_p1 (
    .Clock(Clock), .Resetn(Resetn), .En(En), .Dir(Dir), .Load(Load), .D(D),
    .Q(Q1), .Tick(Tick1), .Tc(Tc1)
  );

  mod_counter #(.N(4), .MODULUS(10), .PRESCALE(3)) u_p3 (
    .Clock(Clock), .Resetn(Resetn), .En(En), .Dir(Dir), .Load(Load), .D(D),
    .Q(Q3), .Tick(Tick3), .Tc(Tc3)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Resetn = 1'b1;
    En     = 1'b0;
    Dir    = 1'b1;
    Load   = 1'b0;
    D      = '0;

    // Reset state
    #2 Resetn = 1'b0;
    #1;
    chk("rst_q1", Q1, 0);
    chk("rst_tick1", Tick1, 0);
    chk("rst_tc1", Tc1, 0);
    chk("rst_q3", Q3, 0);
    chk("rst_tc3", Tc3, 0);
    clk1();
    Resetn = 1'b1;
    En     = 1'b1;
    Dir    = 1'b1;

    // Up count through wrap
    for (int i = 1; i <= 12; i++) begin
      clk1();
      chk($sformatf("up_q_%0d", i), Q1, SAT ? ((i > 9) ? 9 : i) : (i % 10));
      chk($sformatf("up_tick_%0d", i), Tick1, 1);
      chk($sformatf("up_tc_%0d", i), Tc1, SAT ? (i >= 10) : (i == 10));
    end
    En = 1'b0;
    clk1();
    chk("hold_q", Q1, SAT ? 9 : 2);
    chk("hold_tick", Tick1, 0);
    chk("hold_tc", Tc1, 0);

    // Down count from reset
    Resetn = 1'b0;
    #1;
    chk("rstB_q1", Q1, 0);
    chk("rstB_tc1", Tc1, 0);
    Resetn = 1'b1;
    Dir    = 1'b0;
    En     = 1'b1;
    clk1();
    chk("dn_q_1", Q1, SAT ? 0 : 9);
    chk("dn_tc_1", Tc1, 1);
    clk1();
    chk("dn_q_2", Q1, SAT ? 0 : 8);
    chk("dn_tc_2", Tc1, SAT ? 1 : 0);
    clk1();
    chk("dn_q_3", Q1, SAT ? 0 : 7);
    chk("dn_tick_3", Tick1, 1);

    // Prescale-by-3 spacing with a 2-clock En gap
    En     = 1'b0;
    Resetn = 1'b0;
    #1;
    Resetn = 1'b1;
    Dir    = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      En = (k == 7 || k == 8) ? 1'b0 : 1'b1;
      clk1();
      chk($sformatf("ps_tick_%0d", k), Tick3, (k == 3 || k == 6 || k == 11) ? 1 : 0);
      chk($sformatf("ps_q_%0d", k), Q3, (k >= 11) ? 3 : (k >= 6) ? 2 : (k >= 3) ? 1 : 0);
    end

    // Load with clamp
    En   = 1'b0;
    Load = 1'b1;
    D    = 4'd10;
    clk1();
    chk("ld10_q1", Q1, 9);
    chk("ld10_q3", Q3, 9);
    En = 1'b1;
    D  = 4'd15;
    clk1();
    chk("ld15_q1", Q1, 9);
    chk("ld15_tick1", Tick1, 0);
    chk("ld15_tc1", Tc1, 0);
    Load = 1'b0;
    clk1();
    chk("ldstep_q1", Q1, SAT ? 9 : 0);
    chk("ldstep_tc1", Tc1, 1);
    chk("ldstep_tick1", Tick1, 1);
    chk("ldstep_tick3", Tick3, 0);
    chk("ldstep_q3", Q3, 9);

    // Async reset in the middle of a prescale period
    clk1();
    chk("mid_q3_pre", Q3, 9);
    chk("mid_q1_pre", Q1, SAT ? 9 : 1);
    Resetn = 1'b0;
    #3;
    chk("mid_q3", Q3, 0);
    chk("mid_tc3", Tc3, 0);
    chk("mid_q1", Q1, 0);
    Resetn = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      clk1();
      chk($sformatf("rel_tick3_%0d", k), Tick3, (k == 3) ? 1 : 0);
      chk($sformatf("rel_q3_%0d", k), Q3, (k == 3) ? 1 : 0);
    end

    // Terminal behaviour from 8, then direction change
    Load = 1'b1;
    D    = 4'd8;
    Dir  = 1'b1;
    clk1();
    chk("t8_q", Q1, 8);
    Load = 1'b0;
    clk1();
    chk("t8_q_1", Q1, 9);
    chk("t8_tc_1", Tc1, 0);
    clk1();
    chk("t8_q_2", Q1, SAT ? 9 : 0);
    chk("t8_tc_2", Tc1, 1);
    clk1();
    chk("t8_q_3", Q1, SAT ? 9 : 1);
    chk("t8_tc_3", Tc1, SAT ? 1 : 0);
    Dir = 1'b0;
    clk1();
    chk("t8_q_dn", Q1, SAT ? 8 : 0);
    chk("t8_tc_dn", Tc1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter N, default 24: counter width in bits.
REQ-002 Parameter MODULUS, default 2**24: count range is 0..MODULUS-1; legal range is 2 to 2**N inclusive.
REQ-003 Parameter PRESCALE, default 1: number of enabled clocks per count step; legal values are 1 or greater.
REQ-004 Clock  input  1  sole clock; all state changes on its rising edge.
REQ-005 Resetn  input  1  asynchronous, active-low reset.
REQ-006 En  input  1  count enable; when low, the counter and prescaler hold.
REQ-007 Dir  input  1  count direction: 1 = up, 0 = down.
REQ-008 Load  input  1  synchronous load strobe.
REQ-009 D  input  N  load value.
REQ-010 Q  output  N  registered count value.
REQ-011 Tick  output  1  registered one-cycle pulse on each count step.
REQ-012 Tc  output  1  registered one-cycle terminal-count pulse.

Function
REQ-013 Prescaler: P counts 0..PRESCALE-1 on each clock with En=1; it wraps to 0 after PRESCALE-1; a step occurs on a clock where En=1 and P==PRESCALE-1.
REQ-014 With PRESCALE=1, a step occurs on every clock with En=1, and the prescaler logic is optimised away.
REQ-015 Up step: Q <= (Q==MODULUS-1) ? 0 : Q+1.
REQ-016 Down step: Q <= (Q==0) ? MODULUS-1 : Q-1.
REQ-017 Tick is 1 in the cycle after each step edge, and 0 otherwise.
REQ-018 Tc is 1 in the cycle after a step taken from the terminal value: MODULUS-1 when counting up, 0 when counting down.
REQ-019 Load has priority over En and over the step: Q <= D, P <= 0, Tick <= 0, Tc <= 0.
REQ-020 A loaded value D of MODULUS or greater is clamped to MODULUS-1.
REQ-021 Dir is sampled only on step clocks; a change between steps takes effect on the next step and introduces no extra step.
REQ-022 With En=0 and Load=0, Q and P hold and Tick=Tc=0.
REQ-023 Arithmetic is done in N+1 bits internally so that MODULUS=2**N produces no overflow; Q is always below MODULUS.
REQ-024 Step latency is exactly PRESCALE enabled clocks from P=0; Q updates on the step edge with no pipeline delay.

Reset
REQ-025 Resetn=0 immediately forces Q=0, P=0, Tick=0, Tc=0, independent of Clock.
REQ-026 Deassertion of Resetn is sampled synchronously: counting resumes on the first rising edge of Clock with Resetn=1 and En=1.
REQ-027 Reset asserted in the middle of a prescale period discards the partial prescale count.

Configuration
REQ-028 Macro MOD_COUNTER_SATURATE_EN, when defined: a step at the terminal value holds Q (MODULUS-1 when counting up, 0 when counting down) instead of wrapping; Tc still pulses on that step; Tick pulses as normal.
REQ-029 Macro MOD_COUNTER_SATURATE_EN, when undefined: wrap-around behaviour exactly as specified in REQ-015 and REQ-016.

Structure
REQ-030 Package counter_pkg holds: the direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0; a function clog2 used to size the prescaler; the default parameter values.
REQ-031 Sub-module mod_prescaler (parameter PRESCALE; ports Clock, Resetn, En, Clr, Step) implements REQ-013 and REQ-014; mod_counter instantiates it once.
REQ-032 An elaboration-time check rejects MODULUS<2, MODULUS>2**N and PRESCALE<1.

Verification
REQ-033 N=4, MODULUS=10, PRESCALE=1, Dir=1, En=1 held for 12 clocks from reset -> Q = 1..9, 0, 1, 2; a single Tc pulse in the cycle after the 9->0 step.
REQ-034 N=4, MODULUS=10, Dir=0, En=1 from reset -> Q goes 0->9 on the first step, Tc=1 in the following cycle, then Q=8, 7, and so on.
REQ-035 PRESCALE=3, En=1 -> Tick is high exactly once every 3 clocks; a 2-clock gap in En stretches the step spacing to 5 clocks.
REQ-036 Load=1 with D=15, MODULUS=10, while En=1 -> next Q=9, Tick=0, Tc=0; the next up step gives Q=0 and Tc=1.
REQ-037 Resetn driven low for 3 ns mid-prescale between clock edges -> Q and Tc are 0 before the next edge; the first step occurs PRESCALE clocks after release.
REQ-038 MOD_COUNTER_SATURATE_EN defined, up-count from 8 with MODULUS=10 -> Q = 9, 9, 9; Tc pulses after each step at 9; Dir=0 then gives Q=8.
